// File: rtl/uart_rx_mini.sv
// Receive-side mini UART: 8N1 deserialiser feeding a small FIFO drained over APB.
// Drives interrupt, DMA request and RTS flow control from the FIFO state.
module uart_rx_mini #(
    parameter int BIT_CYCLES = 868,
    parameter int DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        rx,
    output logic        rts,
    output logic        irq,
    output logic        dreq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   RTS_LIM   = (AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_t;

    rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta, rx_s;
    logic          rx_push, frame_set;

    logic          access, rd_access, wr_access;
    logic [1:0]    reg_sel;
    logic          pop_req, pop_do, push_do, ovr_set, status_wr;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, level;
    logic          not_empty, full;
    logic          overrun, frame_err, irq_en;
    logic [31:0]   status_word;
    logic          unused_apb;

    // Synchroniser flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        rx_push = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access    = apbs_psel & apbs_penable;
    assign rd_access = access & ~apbs_pwrite;
    assign wr_access = access & apbs_pwrite;
    assign reg_sel   = apbs_paddr[3:2];
    assign status_wr = wr_access && (reg_sel == 2'd1);
    assign unused_apb = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:4], apbs_pwdata[1]};

    assign level     = wr_ptr - rd_ptr;
    assign not_empty = (level != '0);
    assign full      = (level == FULL_LVL);

    // Pop is resolved first so a simultaneous push into a full FIFO still fits.
    assign pop_req = rd_access && (reg_sel == 2'd0);
    assign pop_do  = pop_req & not_empty;
    assign push_do = rx_push & (~full | pop_do);
    assign ovr_set = rx_push & full & ~pop_do;

    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Sticky flags: a set in the same cycle as a software clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (status_wr && apbs_pwdata[2]) begin
                overrun <= 1'b0;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (status_wr && apbs_pwdata[3]) begin
                frame_err <= 1'b0;
            end
            if (wr_access && (reg_sel == 2'd2)) begin
                irq_en <= apbs_pwdata[0];
            end
        end
    end

    assign status_word = {16'b0, 8'(level), 4'b0, frame_err, overrun, full, not_empty};

    always_comb begin
        apbs_prdata = '0;
        if (rd_access) begin
            case (reg_sel)
                2'd0: begin
                    if (not_empty) begin
                        apbs_prdata = {24'b0, mem[rd_ptr[AW-1:0]]};
                    end
                end
                2'd1:    apbs_prdata = status_word;
                2'd2:    apbs_prdata = {31'b0, irq_en};
                default: apbs_prdata = '0;
            endcase
        end
    end

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign dreq         = not_empty;
    assign irq          = irq_en & (not_empty | overrun | frame_err);
    assign rts          = (level < RTS_LIM);

endmodule

// File: tb/tb_uart_rx_mini.sv
// Bench for uart_rx_mini: serial frames driven on rx, FIFO drained over APB,
// results compared with a queue-based model of the receiver's register view.
module tb_uart_rx_mini;

    localparam int BC = 16;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        apbs_psel, apbs_penable, apbs_pwrite;
    logic [15:0] apbs_paddr;
    logic [31:0] apbs_pwdata;
    logic [31:0] apbs_prdata;
    logic        apbs_pready, apbs_pslverr;
    logic        rx, rts, irq, dreq;

    logic [7:0]  model_q[$];
    bit          m_ov, m_fe, m_irq_en;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] rd;
    logic [7:0]  b;

    uart_rx_mini #(.BIT_CYCLES(BC), .DEPTH(DP)) dut (
        .clk(clk),
        .rst(rst),
        .apbs_psel(apbs_psel),
        .apbs_penable(apbs_penable),
        .apbs_pwrite(apbs_pwrite),
        .apbs_paddr(apbs_paddr),
        .apbs_pwdata(apbs_pwdata),
        .apbs_prdata(apbs_prdata),
        .apbs_pready(apbs_pready),
        .apbs_pslverr(apbs_pslverr),
        .rx(rx),
        .rts(rts),
        .irq(irq),
        .dreq(dreq)
    );

    always #5 clk = ~clk;

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Model of the register view
    function automatic logic [31:0] modelStatus();
        logic [7:0] lvl;
        lvl = 8'(model_q.size());
        return {16'b0, lvl, 4'b0, m_fe, m_ov, (model_q.size() == DP), (model_q.size() != 0)};
    endfunction

    function automatic logic modelIrq();
        return m_irq_en & ((model_q.size() != 0) | m_ov | m_fe);
    endfunction

    task automatic modelPush(input logic [7:0] d);
        if (model_q.size() < DP) model_q.push_back(d);
        else m_ov = 1'b1;
    endtask

    task automatic modelReset();
        model_q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        m_irq_en = 1'b0;
    endtask

    task automatic apbRead(input logic [15:0] addr, output logic [31:0] data);
        apbs_psel = 1'b1; apbs_pwrite = 1'b0; apbs_paddr = addr; apbs_penable = 1'b0;
        waitNeg(1);
        apbs_penable = 1'b1;
        #1 data = apbs_prdata;
        waitNeg(1);
        apbs_psel = 1'b0; apbs_penable = 1'b0;
    endtask

    task automatic apbWrite(input logic [15:0] addr, input logic [31:0] data);
        apbs_psel = 1'b1; apbs_pwrite = 1'b1; apbs_paddr = addr; apbs_pwdata = data; apbs_penable = 1'b0;
        waitNeg(1);
        apbs_penable = 1'b1;
        waitNeg(1);
        apbs_psel = 1'b0; apbs_penable = 1'b0; apbs_pwrite = 1'b0;
    endtask

    // One serial frame; optionally issues an RXDATA read whose access cycle
    // lands on the stop-bit sampling cycle (11th clock of the stop bit, given
    // two synchroniser stages, half-bit start delay and full-bit data spacing).
    task automatic applyStimulus(input logic [7:0] data, input bit stop_val,
                                 input bit read_at_push, output logic [31:0] rdv);
        rdv = '0;
        rx = 1'b0;
        waitNeg(BC);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitNeg(BC);
        end
        rx = stop_val;
        if (read_at_push) begin
            waitNeg(9);
            apbs_psel = 1'b1; apbs_pwrite = 1'b0; apbs_paddr = 16'h0; apbs_penable = 1'b0;
            waitNeg(1);
            apbs_penable = 1'b1;
            #1 rdv = apbs_prdata;
            waitNeg(1);
            apbs_psel = 1'b0; apbs_penable = 1'b0;
            waitNeg(BC - 11);
        end else begin
            waitNeg(BC);
        end
    endtask

    task automatic readCheckData(input string tag);
        logic [31:0] v, e;
        e = (model_q.size() != 0) ? {24'b0, model_q.pop_front()} : 32'h0;
        apbRead(16'h0, v);
        checkOutput(tag, v, e);
    endtask

    task automatic readCheckStatus(input string tag);
        logic [31:0] v, e;
        e = modelStatus();
        apbRead(16'h4, v);
        checkOutput(tag, v, e);
    endtask

    task automatic checkPins(input string tag);
        checkOutput({tag, "_dreq"}, {31'b0, dreq}, {31'b0, (model_q.size() != 0)});
        checkOutput({tag, "_rts"},  {31'b0, rts},  {31'b0, (model_q.size() < DP - 1)});
        checkOutput({tag, "_irq"},  {31'b0, irq},  {31'b0, modelIrq()});
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1;
        apbs_psel = 1'b0; apbs_penable = 1'b0; apbs_pwrite = 1'b0;
        apbs_paddr = '0; apbs_pwdata = '0;
        modelReset();
        waitNeg(4);
        rst = 1'b0;
        waitNeg(2);
        $display("[TB] reset state");
        checkPins("reset");
        checkOutput("reset_prdata", apbs_prdata, 32'h0);
        checkOutput("pready", {31'b0, apbs_pready}, 32'h1);
        checkOutput("pslverr", {31'b0, apbs_pslverr}, 32'h0);
        readCheckStatus("reset_status");

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55, 1'b1, 1'b0, rd);
        modelPush(8'h55);
        waitNeg(2);
        checkOutput("one_status_const", modelStatus(), 32'h0000_0101);
        readCheckStatus("one_status");
        checkPins("one");
        readCheckData("one_data");
        readCheckStatus("one_status_after");

        $display("[TB] fill FIFO back-to-back");
        applyStimulus(8'hA5, 1'b1, 1'b0, rd); modelPush(8'hA5);
        applyStimulus(8'h3C, 1'b1, 1'b0, rd); modelPush(8'h3C);
        applyStimulus(8'hFF, 1'b1, 1'b0, rd); modelPush(8'hFF);
        applyStimulus(8'h00, 1'b1, 1'b0, rd); modelPush(8'h00);
        waitNeg(2);
        readCheckStatus("fill_status");
        checkPins("fill");
        for (int i = 0; i < 5; i++) readCheckData($sformatf("fill_rd%0d", i));
        readCheckStatus("fill_drained");

        $display("[TB] overrun");
        applyStimulus(8'hA5, 1'b1, 1'b0, rd); modelPush(8'hA5);
        applyStimulus(8'h3C, 1'b1, 1'b0, rd); modelPush(8'h3C);
        applyStimulus(8'hFF, 1'b1, 1'b0, rd); modelPush(8'hFF);
        applyStimulus(8'h00, 1'b1, 1'b0, rd); modelPush(8'h00);
        applyStimulus(8'h77, 1'b1, 1'b0, rd); modelPush(8'h77);
        waitNeg(2);
        readCheckStatus("ovr_status");
        for (int i = 0; i < 4; i++) readCheckData($sformatf("ovr_rd%0d", i));
        readCheckStatus("ovr_sticky");
        apbWrite(16'h4, 32'h4); m_ov = 1'b0;
        readCheckStatus("ovr_cleared");

        $display("[TB] framing error and break");
        applyStimulus(8'h12, 1'b0, 1'b0, rd);
        m_fe = 1'b1;
        waitNeg(40 * BC);
        rx = 1'b1;
        waitNeg(2 * BC);
        readCheckStatus("fe_status");
        applyStimulus(8'h34, 1'b1, 1'b0, rd); modelPush(8'h34);
        waitNeg(2);
        readCheckStatus("fe_next_status");
        readCheckData("fe_next_data");
        apbWrite(16'h4, 32'h8); m_fe = 1'b0;
        readCheckStatus("fe_cleared");

        $display("[TB] glitch rejection");
        rx = 1'b0; waitNeg(4); rx = 1'b1;
        waitNeg(2 * BC);
        readCheckStatus("glitch_status");
        applyStimulus(8'h81, 1'b1, 1'b0, rd); modelPush(8'h81);
        waitNeg(2);
        readCheckData("glitch_next_data");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b0, rd);
            modelPush(b);
            waitNeg($urandom_range(2, 20));
            if ($urandom_range(0, 2) == 0) readCheckData($sformatf("rnd_rd%0d", n));
            if (n % 4 == 3) begin
                readCheckStatus($sformatf("rnd_st%0d", n));
                apbWrite(16'h4, 32'hC); m_ov = 1'b0; m_fe = 1'b0;
            end
        end
        while (model_q.size() != 0) readCheckData("rnd_drain");
        readCheckStatus("rnd_empty");

        $display("[TB] irq and read at push");
        apbWrite(16'h8, 32'h1); m_irq_en = 1'b1;
        apbRead(16'h8, rd);
        checkOutput("ctrl_rd", rd, 32'h1);
        checkPins("irq_empty");
        for (int i = 0; i < DP; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b0, rd);
            modelPush(b);
        end
        waitNeg(2);
        checkPins("irq_full");
        b = 8'($urandom);
        applyStimulus(b, 1'b1, 1'b1, rd);
        checkOutput("push_pop_data", rd, {24'b0, model_q.pop_front()});
        modelPush(b);
        waitNeg(2);
        readCheckStatus("push_pop_status");
        checkPins("push_pop");
        for (int i = 0; i < DP; i++) readCheckData($sformatf("push_pop_rd%0d", i));

        $display("[TB] reset mid-frame");
        applyStimulus(8'h5A, 1'b1, 1'b0, rd); modelPush(8'h5A);
        rx = 1'b0;
        waitNeg(3 * BC);
        rst = 1'b1;
        waitNeg(2);
        rx = 1'b1;
        rst = 1'b0;
        modelReset();
        waitNeg(2);
        checkPins("midrst");
        checkOutput("midrst_prdata", apbs_prdata, 32'h0);
        readCheckStatus("midrst_status");
        apbRead(16'h8, rd);
        checkOutput("midrst_ctrl", rd, 32'h0);
        apbRead(16'hC, rd);
        checkOutput("unmapped_rd", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_mini.md
# uart_rx_mini

Receive-side companion to the SoC's APB mini UART transmitter: deserialises the `rx` line (8 data bits, 1 start, 1 stop, no parity, LSB first) and buffers bytes in a small FIFO. Software drains the FIFO through an APB slave port. It sits on the same peripheral bus as the transmitter and drives the UART interrupt, DMA request and RTS flow-control lines.

## Interface
Parameters:
- `BIT_CYCLES`, default 868: clk cycles per bit; legal range ≥ 4.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `apbs_psel`  in  1  APB select.
- `apbs_penable`  in  1  APB access phase.
- `apbs_pwrite`  in  1  1 = write.
- `apbs_paddr`  in  16  byte address; only bits [3:2] are decoded.
- `apbs_pwdata`  in  32  write data.
- `apbs_prdata`  out  32  read data; combinational during the access phase.
- `apbs_pready`  out  1  tied 1 (zero wait states).
- `apbs_pslverr`  out  1  tied 0.
- `rx`  in  1  asynchronous serial input; idle high.
- `rts`  out  1  1 = peer may send.
- `irq`  out  1  level interrupt.
- `dreq`  out  1  DMA request: FIFO not empty.

## Operation
Registers (word offsets). Unmapped offsets read 0 and ignore writes.
- 0x0 RXDATA (R): [7:0] = FIFO head; [31:8] = 0.
  - A read pops one entry.
  - A read when empty returns 0 and does not pop.
- 0x4 STATUS:
  - bit0 `not_empty`
  - bit1 `full`
  - bit2 `overrun`, sticky
  - bit3 `frame_err`, sticky
  - [15:8] `level`, 0..DEPTH
  - Writing 1 to bit2 or bit3 clears that flag. Other bits are read-only.
- 0x8 CTRL (R/W): bit0 `irq_en`; reset value 0.

Access and outputs:
- An access is `psel && penable`. Pop and clear happen on that cycle.
- `irq = irq_en & (not_empty | overrun | frame_err)`.
- `dreq = not_empty`.
- `rts = (level < DEPTH-1)`.

Receiver path:
- `rx` passes through a 2-flop synchroniser to give `rx_s`. There is no other filtering.
- A bit counter `cnt` handles timing. An "expiry" is the cycle in which `cnt` reaches 0.

Receiver FSM:
- IDLE: when `rx_s == 0`, load `cnt = BIT_CYCLES/2 - 1` and go to START.
- START: at expiry,
  - if `rx_s == 1`, this is a false start: go to IDLE.
  - otherwise load `cnt = BIT_CYCLES - 1`, clear the bit index, and go to DATA.
- DATA: at each expiry, shift `rx_s` into shift[7] (shift right) and reload `cnt`. After the 8th sample, go to STOP.
- STOP: at expiry,
  - if `rx_s == 1`, push the byte and go to IDLE.
  - if `rx_s == 0`, set `frame_err`, drop the byte, and go to WAIT_HI.
- WAIT_HI: stay until `rx_s == 1`, then go to IDLE. A break condition therefore yields exactly one `frame_err`.

FIFO:
- Storage is a circular buffer with pointers of width log2(DEPTH) plus one wrap bit.
- A push when full with no pop in the same cycle drops the incoming byte and sets `overrun`. FIFO contents are unchanged.
- A push and a pop in the same cycle when full: the pop is applied first, the push is accepted, no overrun is flagged, and `level` is unchanged.
- A push and a pop in the same cycle when empty: the pop is ignored and the push is accepted.
- If a flag clear and a flag set land in the same cycle, the set wins.

## Timing
- Reset state: FSM in IDLE; FIFO empty; all flags 0; `irq_en` 0; synchroniser flops set to 1.
- Outputs after reset: `irq = 0`, `dreq = 0`, `rts = 1`, `apbs_prdata = 0`.
- Reset asserted mid-frame aborts the frame. Bytes already in the FIFO are discarded.
- The first data sample occurs 1.5 bit times (±1 cycle) after the falling edge of `rx`, plus 2 cycles of synchroniser delay.
- Push into the FIFO happens at the stop-bit midpoint. `level`, `dreq` and `irq` update the next cycle.
- RXDATA read: data is valid in the access cycle. `level` decrements the next cycle.
- Back-to-back reads pop consecutive entries.
- No deadlock in any state. The FSM returns to IDLE within 10 bit times unless `rx` is held low, in which case it waits in WAIT_HI.

## Test plan
All directed tests use `BIT_CYCLES=16`, `DEPTH=4`.
- Reset, then send byte 0x55 → STATUS = 0x0000_0101, `dreq = 1`; RXDATA reads 0x55; STATUS then reads 0.
- Send 0xA5, 0x3C, 0xFF, 0x00 back-to-back → `level = 4`, `full = 1`, `rts = 0`; reads return the bytes in order; the 5th read returns 0.
- Fill the FIFO, then send 0x77 → `overrun = 1`; contents still 0xA5, 0x3C, 0xFF, 0x00; writing 0x4 to STATUS clears `overrun`.
- Drive a 0x12 frame with a low stop bit, then hold `rx` low for 40 bit times → exactly one `frame_err`, no push; the next good frame 0x34 is received.
- Apply a 4-cycle low glitch on `rx` → no push, FSM back in IDLE; the following frame 0x81 is received correctly.
- With `irq_en = 1` and a full FIFO, issue an RXDATA read in the same cycle as a stop-bit push → no overrun, `level` stays 4, `irq = 1`; assert `rst` mid-frame → all outputs return to reset values.
